// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and EX-stage data
// requests. Each access holds mem_cs for a fixed wait window, then pulses the owner's done.
//
// state  | meaning
// IDLE   | bus free, arbitrate between fetch and data requests
// ACCESS | mem_cs held, wait counter running down to terminal count
// RESP   | owner's done pulse high, requests ignored
module mem_port_arbiter #(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ex_ena,
   input  logic              ex_rw,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   output logic              ex_done,
   output logic [DATA_W-1:0] ex_rdata,
   output logic              stall_out,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int W_EFF = (WAIT_CYCLES < 1) ? 1 : ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
   localparam logic [3:0] CNT_LOAD = 4'(W_EFF - 1);
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_EX = 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              mem_cs_q, mem_cs_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              if_done_q, if_done_d;
   logic              ex_done_q, ex_done_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ex_rdata_q, ex_rdata_d;
   logic              grant_ex;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         owner_q      <= OWN_IF;
         last_grant_q <= OWN_IF;
         mem_cs_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_done_q    <= 1'b0;
         ex_done_q    <= 1'b0;
         if_rdata_q   <= '0;
         ex_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         mem_cs_q     <= mem_cs_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_done_q    <= if_done_d;
         ex_done_q    <= ex_done_d;
         if_rdata_q   <= if_rdata_d;
         ex_rdata_q   <= ex_rdata_d;
      end
   end

   // On a tie the requester that did not win last time takes the bus.
   assign grant_ex = ex_ena & (~if_req | (last_grant_q == OWN_IF));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      mem_cs_d     = mem_cs_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_done_d    = 1'b0;
      ex_done_d    = 1'b0;
      if_rdata_d   = if_rdata_q;
      ex_rdata_d   = ex_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (if_req | ex_ena) begin
               owner_d      = grant_ex;
               last_grant_d = grant_ex;
               mem_addr_d   = grant_ex ? ex_addr : if_addr;
               mem_we_d     = grant_ex & ex_rw;
               mem_wdata_d  = grant_ex ? ex_wdata : '0;
               mem_cs_d     = 1'b1;
               cnt_d        = CNT_LOAD;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (owner_q == OWN_EX) begin
                  ex_done_d = 1'b1;
                  if (!mem_we_q) ex_rdata_d = mem_rdata;
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = mem_rdata;
               end
               mem_cs_d   = 1'b0;
               mem_we_d   = 1'b0;
               mem_addr_d = '0;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign if_done   = if_done_q;
   assign ex_done   = ex_done_q;
   assign if_rdata  = if_rdata_q;
   assign ex_rdata  = ex_rdata_q;
   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign stall_out = (ex_ena & ~ex_done_q) | (if_req & ~if_done_q);

endmodule
